// File: rtl/pb_pkg.sv
// Shared types, default parameters and width helper for the push-button mode controller.
package pb_pkg;

    localparam int DB_CYC_DEF   = 16;
    localparam int LONG_CYC_DEF = 50000;

    typedef enum logic [1:0] {
        REL      = 2'd0,
        PRS      = 2'd1,
        PRS_LONG = 2'd2
    } chan_state_t;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pb_mode_ctrl_if.sv
// Button/setting bundle between the handlebar buttons, the mode controller and the assist logic.
interface pb_mode_ctrl_if
    import pb_pkg::*;
#(
    parameter int NUM_CH  = 1,
    parameter int NUM_SET = 4
);
    localparam int SET_W = cnt_width(NUM_SET);

    logic [NUM_CH-1:0]       btn_n;
    logic [NUM_CH*SET_W-1:0] setting;
    logic [NUM_CH-1:0]       short_pulse;
    logic [NUM_CH-1:0]       long_pulse;

    modport master (
        output btn_n,
        input  setting,
        input  short_pulse,
        input  long_pulse
    );

    modport slave (
        input  btn_n,
        output setting,
        output short_pulse,
        output long_pulse
    );

endinterface

// File: rtl/pb_chan.sv
// One button channel: synchroniser, debouncer, press/release FSM and wrap-around setting counter.
// Long-press restore to the default setting is built only when PB_LONG_PRESS_EN is defined.
module pb_chan
    import pb_pkg::*;
#(
    parameter  int NUM_SET  = 4,
    parameter  int RST_SET  = 2,
    parameter  int DB_CYC   = DB_CYC_DEF,
    parameter  int LONG_CYC = LONG_CYC_DEF,
    localparam int SET_W    = cnt_width(NUM_SET)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_n,
    output logic [SET_W-1:0] setting,
    output logic             short_pulse,
    output logic             long_pulse
);

    localparam int DBC_W = cnt_width(DB_CYC);

    if (NUM_SET < 2 || RST_SET < 0 || RST_SET >= NUM_SET || DB_CYC < 1 || LONG_CYC <= DB_CYC) begin : g_param_err
        $error("pb_chan: illegal parameter combination");
    end

    logic [1:0]       sync_reg;
    logic             db_reg;
    logic [DBC_W-1:0] dbc_reg;

    chan_state_t      state_reg, state_next;
    logic [SET_W-1:0] setting_reg, setting_next;
    logic             short_reg, short_next;

    // Debounced level only flips after DB_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
            db_reg   <= 1'b1;
            dbc_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], btn_n};
            if (sync_reg[1] != db_reg) begin
                if (dbc_reg == DBC_W'(DB_CYC - 1)) begin
                    db_reg  <= ~db_reg;
                    dbc_reg <= '0;
                end else begin
                    dbc_reg <= dbc_reg + 1'b1;
                end
            end else begin
                dbc_reg <= '0;
            end
        end
    end

`ifdef PB_LONG_PRESS_EN
    localparam int HOLD_W = cnt_width(LONG_CYC + 1);

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              long_reg, long_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg <= '0;
            long_reg <= 1'b0;
        end else begin
            hold_reg <= hold_next;
            long_reg <= long_next;
        end
    end

    assign long_pulse = long_reg;
`else
    assign long_pulse = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= REL;
            setting_reg <= SET_W'(RST_SET);
            short_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            setting_reg <= setting_next;
            short_reg   <= short_next;
        end
    end

    // The FSM lags db by one cycle, so a state/db disagreement is the press or release edge.
    always_comb begin
        state_next   = state_reg;
        setting_next = setting_reg;
        short_next   = 1'b0;
`ifdef PB_LONG_PRESS_EN
        hold_next    = hold_reg;
        long_next    = 1'b0;
`endif
        case (state_reg)
            REL: begin
                if (!db_reg) begin
                    state_next = PRS;
`ifdef PB_LONG_PRESS_EN
                    hold_next  = '0;
`endif
                end
            end
            PRS: begin
                if (db_reg) begin
                    state_next   = REL;
                    short_next   = 1'b1;
                    setting_next = (setting_reg == SET_W'(NUM_SET - 1)) ? '0 : setting_reg + 1'b1;
                end
`ifdef PB_LONG_PRESS_EN
                else if (hold_reg == HOLD_W'(LONG_CYC - 1)) begin
                    // Counter parks at LONG_CYC; PRS_LONG never re-arms until the next press.
                    state_next   = PRS_LONG;
                    hold_next    = HOLD_W'(LONG_CYC);
                    long_next    = 1'b1;
                    setting_next = SET_W'(RST_SET);
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
`endif
            end
            PRS_LONG: begin
                if (db_reg) begin
                    state_next = REL;
                end
            end
            default: begin
                state_next = REL;
            end
        endcase
    end

    assign setting     = setting_reg;
    assign short_pulse = short_reg;

endmodule

// File: rtl/pb_mode_ctrl.sv
// Multi-channel push-button mode controller: one independent pb_chan per button, outputs packed.
// Optional long-press default restore is enabled with PB_LONG_PRESS_EN.
module pb_mode_ctrl
    import pb_pkg::*;
#(
    parameter  int NUM_CH   = 1,
    parameter  int NUM_SET  = 4,
    parameter  int RST_SET  = 2,
    parameter  int DB_CYC   = DB_CYC_DEF,
    parameter  int LONG_CYC = LONG_CYC_DEF,
    localparam int SET_W    = cnt_width(NUM_SET)
) (
    input  logic          clk,
    input  logic          rst,
    pb_mode_ctrl_if.slave bus
);

    logic [NUM_CH*SET_W-1:0] setting;
    logic [NUM_CH-1:0]       short_pulse;
    logic [NUM_CH-1:0]       long_pulse;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        pb_chan #(
            .NUM_SET  (NUM_SET),
            .RST_SET  (RST_SET),
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .btn_n       (bus.btn_n[gi]),
            .setting     (setting[gi*SET_W +: SET_W]),
            .short_pulse (short_pulse[gi]),
            .long_pulse  (long_pulse[gi])
        );
    end

    assign bus.setting     = setting;
    assign bus.short_pulse = short_pulse;
    assign bus.long_pulse  = long_pulse;

endmodule

// File: tb/tb_pb_mode_ctrl.sv
// Directed self-checking bench for pb_mode_ctrl (3 channels, NUM_SET=4, DB_CYC=4, LONG_CYC=100).
module tb_pb_mode_ctrl;

    localparam int NCH  = 3;
    localparam int NSET = 4;
    localparam int RSET = 2;
    localparam int DB   = 4;
    localparam int LONG = 100;
    localparam int SW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pb_mode_ctrl_if #(.NUM_CH(NCH), .NUM_SET(NSET)) bus ();

    pb_mode_ctrl #(
        .NUM_CH   (NCH),
        .NUM_SET  (NSET),
        .RST_SET  (RSET),
        .DB_CYC   (DB),
        .LONG_CYC (LONG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sp_cnt  [NCH];
    int lp_cnt  [NCH];
    int sp_last [NCH];

    function automatic int get_set(input int ch);
        logic [NCH*SW-1:0] s;
        s = bus.setting;
        return int'(s[ch*SW +: SW]);
    endfunction

    task automatic clear_cnt();
        for (int c = 0; c < NCH; c++) begin
            sp_cnt[c]  = 0;
            lp_cnt[c]  = 0;
            sp_last[c] = -1;
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < NCH; c++) begin
                if (bus.short_pulse[c] === 1'b1) begin
                    sp_cnt[c]++;
                    sp_last[c] = cyc;
                end
                if (bus.long_pulse[c] === 1'b1) lp_cnt[c]++;
            end
        end
    endtask

    task automatic press_release(input int ch);
        bus.btn_n[ch] = 1'b0;
        run(12);
        bus.btn_n[ch] = 1'b1;
        run(12);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.btn_n = '1;
        run(3);
        checks++;
        if (bus.setting !== 6'b10_10_10) begin
            errors++;
            $display("FAIL reset_setting: got %b expected %b", bus.setting, 6'b10_10_10);
        end
        checks++;
        if (bus.short_pulse !== 3'b000 || bus.long_pulse !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got short %b long %b expected 000 000", bus.short_pulse, bus.long_pulse);
        end
        rst = 1'b0;
        run(3);
        $display("reset: setting=%b", bus.setting);
    endtask

    task automatic test_short_press();
        int exp_seq [3] = '{3, 0, 1};
        int prev = 2;
        int rel;
        for (int k = 0; k < 3; k++) begin
            clear_cnt();
            bus.btn_n[0] = 1'b0;
            run(12);
            checks++;
            if (sp_cnt[0] != 0 || get_set(0) != prev) begin
                errors++;
                $display("FAIL press_no_advance: got pulses %0d setting %0d expected 0 %0d", sp_cnt[0], get_set(0), prev);
            end
            bus.btn_n[0] = 1'b1;
            rel = cyc;
            run(12);
            checks++;
            if (sp_cnt[0] != 1) begin
                errors++;
                $display("FAIL short_count: got %0d expected 1", sp_cnt[0]);
            end
            checks++;
            if (sp_last[0] != rel + 7) begin
                errors++;
                $display("FAIL short_latency: got cycle %0d expected %0d", sp_last[0], rel + 7);
            end
            checks++;
            if (get_set(0) != exp_seq[k]) begin
                errors++;
                $display("FAIL short_setting: got %0d expected %0d", get_set(0), exp_seq[k]);
            end
            $display("short press %0d: setting=%0d pulses=%0d", k, get_set(0), sp_cnt[0]);
            prev = exp_seq[k];
        end
        checks++;
        if (get_set(1) != 2 || get_set(2) != 2) begin
            errors++;
            $display("FAIL idle_channels: got %0d %0d expected 2 2", get_set(1), get_set(2));
        end
    endtask

    task automatic test_glitch();
        int rel;
        clear_cnt();
        bus.btn_n[0] = 1'b0;
        run(3);
        bus.btn_n[0] = 1'b1;
        run(15);
        checks++;
        if (sp_cnt[0] != 0 || get_set(0) != 1) begin
            errors++;
            $display("FAIL glitch_reject: got pulses %0d setting %0d expected 0 1", sp_cnt[0], get_set(0));
        end
        $display("glitch: setting=%0d pulses=%0d", get_set(0), sp_cnt[0]);

        bus.btn_n[0] = 1'b0;
        run(12);
        clear_cnt();
        for (int b = 0; b < 3; b++) begin
            bus.btn_n[0] = 1'b1;
            run(2);
            bus.btn_n[0] = 1'b0;
            run(2);
        end
        checks++;
        if (sp_cnt[0] != 0) begin
            errors++;
            $display("FAIL bounce_early: got pulses %0d expected 0", sp_cnt[0]);
        end
        bus.btn_n[0] = 1'b1;
        rel = cyc;
        run(12);
        checks++;
        if (sp_cnt[0] != 1 || sp_last[0] != rel + 7) begin
            errors++;
            $display("FAIL bounce_single: got pulses %0d at %0d expected 1 at %0d", sp_cnt[0], sp_last[0], rel + 7);
        end
        checks++;
        if (get_set(0) != 2) begin
            errors++;
            $display("FAIL bounce_setting: got %0d expected 2", get_set(0));
        end
        $display("bounce: setting=%0d pulses=%0d", get_set(0), sp_cnt[0]);
    endtask

    task automatic test_long_press();
`ifdef PB_LONG_PRESS_EN
        localparam int EXP_LP   = 1;
        localparam int EXP_HOLD = 2;
        localparam int EXP_SP   = 0;
        localparam int EXP_REL  = 2;
`else
        localparam int EXP_LP   = 0;
        localparam int EXP_HOLD = 0;
        localparam int EXP_SP   = 1;
        localparam int EXP_REL  = 1;
`endif
        press_release(0);
        press_release(0);
        checks++;
        if (get_set(0) != 0) begin
            errors++;
            $display("FAIL long_precond: got %0d expected 0", get_set(0));
        end
        clear_cnt();
        bus.btn_n[0] = 1'b0;
        run(150);
        checks++;
        if (lp_cnt[0] != EXP_LP) begin
            errors++;
            $display("FAIL long_count: got %0d expected %0d", lp_cnt[0], EXP_LP);
        end
        checks++;
        if (get_set(0) != EXP_HOLD || sp_cnt[0] != 0) begin
            errors++;
            $display("FAIL long_hold: got setting %0d short %0d expected %0d 0", get_set(0), sp_cnt[0], EXP_HOLD);
        end
        bus.btn_n[0] = 1'b1;
        run(12);
        checks++;
        if (sp_cnt[0] != EXP_SP || get_set(0) != EXP_REL) begin
            errors++;
            $display("FAIL long_release: got short %0d setting %0d expected %0d %0d", sp_cnt[0], get_set(0), EXP_SP, EXP_REL);
        end
        checks++;
        if (lp_cnt[0] != EXP_LP || bus.long_pulse[1] !== 1'b0 || bus.long_pulse[2] !== 1'b0) begin
            errors++;
            $display("FAIL long_total: got %0d expected %0d", lp_cnt[0], EXP_LP);
        end
        $display("long press: setting=%0d long=%0d short=%0d", get_set(0), lp_cnt[0], sp_cnt[0]);
    endtask

    task automatic test_simultaneous();
`ifdef PB_LONG_PRESS_EN
        localparam int EXP0 = 3;
`else
        localparam int EXP0 = 2;
`endif
        int rel;
        clear_cnt();
        bus.btn_n = 3'b010;
        run(12);
        bus.btn_n = 3'b111;
        rel = cyc;
        run(12);
        checks++;
        if (sp_cnt[0] != 1 || sp_last[0] != rel + 7) begin
            errors++;
            $display("FAIL simul_ch0: got %0d pulses at %0d expected 1 at %0d", sp_cnt[0], sp_last[0], rel + 7);
        end
        checks++;
        if (sp_cnt[2] != 1 || sp_last[2] != rel + 7) begin
            errors++;
            $display("FAIL simul_ch2: got %0d pulses at %0d expected 1 at %0d", sp_cnt[2], sp_last[2], rel + 7);
        end
        checks++;
        if (sp_cnt[1] != 0 || get_set(1) != 2) begin
            errors++;
            $display("FAIL simul_ch1: got pulses %0d setting %0d expected 0 2", sp_cnt[1], get_set(1));
        end
        checks++;
        if (get_set(0) != EXP0 || get_set(2) != 3) begin
            errors++;
            $display("FAIL simul_settings: got %0d %0d expected %0d 3", get_set(0), get_set(2), EXP0);
        end
        $display("simultaneous: settings=%0d %0d %0d", get_set(0), get_set(1), get_set(2));
    endtask

    task automatic test_reset_mid_press();
`ifdef PB_LONG_PRESS_EN
        localparam int EXP0 = 0;
`else
        localparam int EXP0 = 3;
`endif
        int rel;
        press_release(0);
        checks++;
        if (get_set(0) != EXP0) begin
            errors++;
            $display("FAIL pre_reset: got %0d expected %0d", get_set(0), EXP0);
        end
        bus.btn_n[0] = 1'b0;
        run(12);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.setting !== 6'b10_10_10 || bus.short_pulse !== 3'b000) begin
            errors++;
            $display("FAIL mid_press_reset: got %b short %b expected 101010 000", bus.setting, bus.short_pulse);
        end
        run(2);
        rst = 1'b0;
        run(12);
        clear_cnt();
        bus.btn_n[0] = 1'b1;
        rel = cyc;
        run(12);
        checks++;
        if (sp_cnt[0] != 1 || sp_last[0] != rel + 7) begin
            errors++;
            $display("FAIL redetect_pulse: got %0d pulses at %0d expected 1 at %0d", sp_cnt[0], sp_last[0], rel + 7);
        end
        checks++;
        if (bus.setting !== 6'b10_10_11) begin
            errors++;
            $display("FAIL redetect_setting: got %b expected %b", bus.setting, 6'b10_10_11);
        end
        $display("reset mid-press: setting=%b", bus.setting);
    endtask

    initial begin
        bus.btn_n = '1;
        clear_cnt();
        test_reset();
        test_short_press();
        test_glitch();
        test_long_press();
        test_simultaneous();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
